mem_op_sequencer: RTL and testbench

Control-step sequencer for memory-reference instructions: ld, ldi and st.
It generates the per-step datapath control strobes that bench FSMs currently hand-code. It runs fetch (T0–T2) followed by the execute steps for each instruction.
Generalised over fixed-timing sequencing: variable-latency RAM handshake with timeout, illegal-opcode detection, and optional back-to-back fetch.
It sits beside Datapath and drives its control inputs directly.

---
 rtl/cpu_ctrl_pkg.sv | 19 +
 rtl/mem_op_sequencer_if.sv | 35 +++
 rtl/mem_op_sequencer_mem_wait_timer.sv | 35 +++
 rtl/mem_op_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mem_op_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes and control-step state encoding for the memory-reference sequencer.
// Pure declarations; no timing or flow control of its own.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE, ILL, ERR
  } state_e;

  // Steps that wait on the RAM handshake: fetch read, ld operand read, st write.
  function automatic logic is_mem_step(input state_e s, input logic ld, input logic st);
    return (s == T1) || ((s == T6) && ld) || ((s == T7) && st);
  endfunction

endpackage

// File: rtl/mem_op_sequencer_if.sv
// Sequencer <-> datapath/RAM control bundle; master is the sequencer side.
// Level signals only: RAM completion arrives on mem_ready, no other backpressure.
interface mem_op_sequencer_if #(
  parameter int OPC_W = 5
);
  logic             start;
  logic [OPC_W-1:0] ir_opcode;
  logic             mem_ready;

  logic PC_out, MAR_enable, PC_enable, IncPC;
  logic Read, MDR_enable, MDR_out, IR_enable;
  logic Gra, Grb, BA_out, R_in, R_out;
  logic Y_enable, C_out, Z_enable, ZLow_out;
  logic RAM_write_enable;
  logic [OPC_W-1:0] alu_op;
  logic busy, done, illegal, timeout;

  modport master (
    input  start, ir_opcode, mem_ready,
    output PC_out, MAR_enable, PC_enable, IncPC,
           Read, MDR_enable, MDR_out, IR_enable,
           Gra, Grb, BA_out, R_in, R_out,
           Y_enable, C_out, Z_enable, ZLow_out,
           RAM_write_enable, alu_op, busy, done, illegal, timeout
  );

  modport slave (
    output start, ir_opcode, mem_ready,
    input  PC_out, MAR_enable, PC_enable, IncPC,
           Read, MDR_enable, MDR_out, IR_enable,
           Gra, Grb, BA_out, R_in, R_out,
           Y_enable, C_out, Z_enable, ZLow_out,
           RAM_write_enable, alu_op, busy, done, illegal, timeout
  );
endinterface

// File: rtl/mem_op_sequencer_mem_wait_timer.sv
// Wait counter for one memory step; expired_o flags the last permitted wait cycle.
// Counter updates one cycle after clear_i/inc_i; no backpressure.
module mem_wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_op_sequencer.sv
// Moore control-step sequencer for ld/ldi/st: fetch T0-T2 then execute steps, strobes decoded from state.
// ldi 7 cycles, ld/st 9 cycles start-to-done with mem_ready high; memory steps stall on mem_ready up to MAX_WAIT.
module mem_op_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_WAIT   = 8,
  parameter int OPC_W      = 5,
  parameter int AUTO_FETCH = 0
) (
  input logic               clk,
  input logic               clr,
  mem_op_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic             is_ld, is_ldi, is_st, op_legal;
  logic             mem_step, expired;

  assign is_ld    = (op_q == OPC_W'(OP_LD));
  assign is_ldi   = (op_q == OPC_W'(OP_LDI));
  assign is_st    = (op_q == OPC_W'(OP_ST));
  assign op_legal = (bus.ir_opcode == OPC_W'(OP_LD))  ||
                    (bus.ir_opcode == OPC_W'(OP_LDI)) ||
                    (bus.ir_opcode == OPC_W'(OP_ST));
  assign mem_step = is_mem_step(state_q, is_ld, is_st);

  // Mem steps are never adjacent, so holding the counter clear outside them gives a fresh count on entry.
  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk       (clk),
    .rst       (clr),
    .clear_i   (!mem_step),
    .inc_i     (mem_step && !bus.mem_ready),
    .expired_o (expired)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE: if (bus.start) state_d = T0;
      T0:   state_d = T1;
      T1: begin
        if (bus.mem_ready)  state_d = T2;
        else if (expired)   state_d = ERR;
      end
      T2:   state_d = T3;
      T3: begin
        op_d    = bus.ir_opcode;
        state_d = op_legal ? T4 : ILL;
      end
      T4:   state_d = T5;
      T5:   state_d = is_ldi ? DONE : T6;
      T6: begin
        if (!is_ld || bus.mem_ready) state_d = T7;
        else if (expired)            state_d = ERR;
      end
      T7: begin
        if (!is_st || bus.mem_ready) state_d = DONE;
        else if (expired)            state_d = ERR;
      end
      DONE: state_d = ((AUTO_FETCH != 0) && bus.start) ? T0 : IDLE;
      ILL:  state_d = IDLE;
      ERR:  if (bus.start) state_d = T0;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.PC_out           = 1'b0;
    bus.MAR_enable       = 1'b0;
    bus.PC_enable        = 1'b0;
    bus.IncPC            = 1'b0;
    bus.Read             = 1'b0;
    bus.MDR_enable       = 1'b0;
    bus.MDR_out          = 1'b0;
    bus.IR_enable        = 1'b0;
    bus.Gra              = 1'b0;
    bus.Grb              = 1'b0;
    bus.BA_out           = 1'b0;
    bus.R_in             = 1'b0;
    bus.R_out            = 1'b0;
    bus.Y_enable         = 1'b0;
    bus.C_out            = 1'b0;
    bus.Z_enable         = 1'b0;
    bus.ZLow_out         = 1'b0;
    bus.RAM_write_enable = 1'b0;
    bus.alu_op           = '0;
    bus.done             = 1'b0;
    bus.illegal          = 1'b0;
    bus.timeout          = 1'b0;
    case (state_q)
      T0: begin
        bus.PC_out     = 1'b1;
        bus.MAR_enable = 1'b1;
        bus.PC_enable  = 1'b1;
        bus.IncPC      = 1'b1;
      end
      T1: begin
        bus.Read       = 1'b1;
        bus.MDR_enable = 1'b1;
      end
      T2: begin
        bus.MDR_out   = 1'b1;
        bus.IR_enable = 1'b1;
      end
      T3: begin
        bus.Grb      = 1'b1;
        bus.BA_out   = 1'b1;
        bus.Y_enable = 1'b1;
      end
      T4: begin
        bus.C_out    = 1'b1;
        bus.Z_enable = 1'b1;
        bus.alu_op   = OPC_W'(ALU_ADD);
      end
      T5: begin
        bus.ZLow_out = 1'b1;
        if (is_ldi) begin
          bus.Gra  = 1'b1;
          bus.R_in = 1'b1;
        end else begin
          bus.MAR_enable = 1'b1;
        end
      end
      T6: begin
        bus.MDR_enable = 1'b1;
        if (is_ld) begin
          bus.Read = 1'b1;
        end else begin
          bus.Gra   = 1'b1;
          bus.R_out = 1'b1;
        end
      end
      T7: begin
        if (is_st) begin
          bus.RAM_write_enable = 1'b1;
        end else begin
          bus.MDR_out = 1'b1;
          bus.Gra     = 1'b1;
          bus.R_in    = 1'b1;
        end
      end
      DONE: bus.done = 1'b1;
      ILL: begin
        bus.done    = 1'b1;
        bus.illegal = 1'b1;
      end
      ERR: bus.timeout = 1'b1;
      default: ;
    endcase
    bus.busy = (state_q != IDLE) && (state_q != ERR);
  end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Bench for mem_op_sequencer: one instance with defaults, one with MAX_WAIT=4 and AUTO_FETCH=1.
// Per-cycle expected control words queued at start, popped and compared each cycle.
module tb_mem_op_sequencer;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010;

  localparam logic [17:0] M_PCO = 18'h20000, M_MARE = 18'h10000, M_PCE = 18'h08000, M_INC = 18'h04000;
  localparam logic [17:0] M_RD  = 18'h02000, M_MDRE = 18'h01000, M_MDRO = 18'h00800, M_IRE = 18'h00400;
  localparam logic [17:0] M_GRA = 18'h00200, M_GRB  = 18'h00100, M_BAO  = 18'h00080, M_RIN = 18'h00040;
  localparam logic [17:0] M_ROUT = 18'h00020, M_YE  = 18'h00010, M_CO   = 18'h00008, M_ZE  = 18'h00004;
  localparam logic [17:0] M_ZLO = 18'h00002, M_WE   = 18'h00001;

  localparam logic [17:0] W_F0 = M_PCO | M_MARE | M_PCE | M_INC;
  localparam logic [17:0] W_F1 = M_RD | M_MDRE;
  localparam logic [17:0] W_F2 = M_MDRO | M_IRE;
  localparam logic [17:0] W_E3 = M_GRB | M_BAO | M_YE;
  localparam logic [17:0] W_E4 = M_CO | M_ZE;
  localparam logic [17:0] W_E5I = M_ZLO | M_GRA | M_RIN;
  localparam logic [17:0] W_E5M = M_ZLO | M_MARE;
  localparam logic [17:0] W_E6L = M_RD | M_MDRE;
  localparam logic [17:0] W_E6S = M_GRA | M_ROUT | M_MDRE;
  localparam logic [17:0] W_E7L = M_MDRO | M_GRA | M_RIN;
  localparam logic [17:0] W_E7S = M_WE;

  // status = {busy, done, illegal, timeout}
  localparam logic [3:0] S_IDLE = 4'b0000, S_BUSY = 4'b1000, S_DONE = 4'b1100;
  localparam logic [3:0] S_ILL  = 4'b1110, S_ERR  = 4'b0001;

  typedef struct packed {
    logic [17:0] word;
    logic [4:0]  alu;
    logic [3:0]  st;
    logic        rdy;
  } step_t;

  typedef struct {
    string      name;
    int         sel;
    logic [4:0] op;
    int         t1s;
    int         xs;
    int         lat;
    int         we;
    logic       ill;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr, start, mem_ready;
  logic [4:0] ir_opcode;
  int         sel;
  int         n_checks = 0;
  int         n_fail = 0;
  step_t      exp_q[$];
  vec_t       vecs[10];

  always #5 clk = ~clk;

  mem_op_sequencer_if #(.OPC_W(5)) ifa ();
  mem_op_sequencer_if #(.OPC_W(5)) ifb ();

  assign ifa.start     = (sel == 0) ? start : 1'b0;
  assign ifb.start     = (sel == 1) ? start : 1'b0;
  assign ifa.mem_ready = mem_ready;
  assign ifb.mem_ready = mem_ready;
  assign ifa.ir_opcode = ir_opcode;
  assign ifb.ir_opcode = ir_opcode;

  mem_op_sequencer #(.MAX_WAIT(8), .OPC_W(5), .AUTO_FETCH(0)) dut_a (.clk(clk), .clr(clr), .bus(ifa));
  mem_op_sequencer #(.MAX_WAIT(4), .OPC_W(5), .AUTO_FETCH(1)) dut_b (.clk(clk), .clr(clr), .bus(ifb));

  logic [17:0] wa, wb, obs_word;
  logic [3:0]  sa, sb, obs_st;
  logic [4:0]  obs_alu;

  assign wa = {ifa.PC_out, ifa.MAR_enable, ifa.PC_enable, ifa.IncPC, ifa.Read, ifa.MDR_enable,
               ifa.MDR_out, ifa.IR_enable, ifa.Gra, ifa.Grb, ifa.BA_out, ifa.R_in, ifa.R_out,
               ifa.Y_enable, ifa.C_out, ifa.Z_enable, ifa.ZLow_out, ifa.RAM_write_enable};
  assign wb = {ifb.PC_out, ifb.MAR_enable, ifb.PC_enable, ifb.IncPC, ifb.Read, ifb.MDR_enable,
               ifb.MDR_out, ifb.IR_enable, ifb.Gra, ifb.Grb, ifb.BA_out, ifb.R_in, ifb.R_out,
               ifb.Y_enable, ifb.C_out, ifb.Z_enable, ifb.ZLow_out, ifb.RAM_write_enable};
  assign sa = {ifa.busy, ifa.done, ifa.illegal, ifa.timeout};
  assign sb = {ifb.busy, ifb.done, ifb.illegal, ifb.timeout};
  assign obs_word = (sel == 1) ? wb : wa;
  assign obs_st   = (sel == 1) ? sb : sa;
  assign obs_alu  = (sel == 1) ? ifb.alu_op : ifa.alu_op;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %h required %h", name, cyc, act, req);
    end
  endtask

  task automatic push(input logic [17:0] w, input logic [4:0] a, input logic [3:0] s, input logic r);
    step_t e;
    e.word = w; e.alu = a; e.st = s; e.rdy = r;
    exp_q.push_back(e);
  endtask

  task automatic expand(input logic [4:0] op, input int t1s, input int xs);
    push(W_F0, 5'd0, S_BUSY, 1'b1);
    for (int i = 0; i < t1s; i++) push(W_F1, 5'd0, S_BUSY, 1'b0);
    push(W_F1, 5'd0, S_BUSY, 1'b1);
    push(W_F2, 5'd0, S_BUSY, 1'b1);
    push(W_E3, 5'd0, S_BUSY, 1'b1);
    if (op != LD && op != LDI && op != ST) begin
      push(18'd0, 5'd0, S_ILL, 1'b1);
    end else begin
      push(W_E4, 5'd3, S_BUSY, 1'b1);
      if (op == LDI) begin
        push(W_E5I, 5'd0, S_BUSY, 1'b1);
      end else if (op == LD) begin
        push(W_E5M, 5'd0, S_BUSY, 1'b1);
        for (int i = 0; i < xs; i++) push(W_E6L, 5'd0, S_BUSY, 1'b0);
        push(W_E6L, 5'd0, S_BUSY, 1'b1);
        push(W_E7L, 5'd0, S_BUSY, 1'b1);
      end else begin
        push(W_E5M, 5'd0, S_BUSY, 1'b1);
        push(W_E6S, 5'd0, S_BUSY, 1'b1);
        for (int i = 0; i < xs; i++) push(W_E7S, 5'd0, S_BUSY, 1'b0);
        push(W_E7S, 5'd0, S_BUSY, 1'b1);
      end
      push(18'd0, 5'd0, S_DONE, 1'b1);
    end
    push(18'd0, 5'd0, S_IDLE, 1'b1);
  endtask

  // Entered #1 after a rising edge; leaves at the same phase.
  task automatic run_op(input vec_t v);
    int    cyc, done_cyc, we_cnt;
    logic  ill_seen;
    step_t e;
    sel = v.sel; ir_opcode = v.op; mem_ready = 1'b1;
    expand(v.op, v.t1s, v.xs);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; done_cyc = -1; we_cnt = 0; ill_seen = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      mem_ready = e.rdy;
      if (cyc > v.t1s + 4) ir_opcode = ~v.op;
      @(negedge clk);
      check({v.name, " trace"}, cyc, {5'd0, obs_word, obs_alu, obs_st}, {5'd0, e.word, e.alu, e.st});
      if (obs_st[2] && done_cyc < 0) done_cyc = cyc;
      if (obs_word[0]) we_cnt++;
      if (obs_st[1]) ill_seen = 1'b1;
      @(posedge clk); #1;
    end
    check({v.name, " latency"}, cyc, done_cyc, v.lat);
    check({v.name, " write_cycles"}, cyc, we_cnt, v.we);
    check({v.name, " illegal"}, cyc, {31'd0, ill_seen}, {31'd0, v.ill});
    mem_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, nd, cyc;
    vec_t v;

    vecs[0] = '{"ldi",          0, LDI,      0, 0,  7, 0, 1'b0};
    vecs[1] = '{"ld_stall3",    0, LD,       0, 3, 12, 0, 1'b0};
    vecs[2] = '{"st",           0, ST,       0, 0,  9, 1, 1'b0};
    vecs[3] = '{"ld_fetch2",    0, LD,       2, 0, 11, 0, 1'b0};
    vecs[4] = '{"st_stall",     0, ST,       1, 2, 12, 3, 1'b0};
    vecs[5] = '{"ill_01100",    0, 5'b01100, 0, 0,  5, 0, 1'b1};
    vecs[6] = '{"ld_maxwait",   0, LD,       0, 7, 16, 0, 1'b0};
    vecs[7] = '{"ldi_maxfetch", 0, LDI,      7, 0, 14, 0, 1'b0};
    vecs[8] = '{"ill_11111",    0, 5'b11111, 0, 0,  5, 0, 1'b1};
    vecs[9] = '{"b_ld_max4",    1, LD,       3, 0, 12, 0, 1'b0};

    clr = 1'b1; start = 1'b0; mem_ready = 1'b1; ir_opcode = 5'd0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      check("reset_outputs", s, {5'd0, obs_word, obs_alu, obs_st}, 32'd0);
    end
    clr = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Timeout on fetch read with MAX_WAIT=4, then recovery via start.
    sel = 1; ir_opcode = LDI; mem_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 1; cyc <= 9; cyc++) begin
      if (cyc == 9) start = 1'b1;
      @(negedge clk);
      if (cyc == 1)      check("err_t0", cyc, {obs_word, obs_st}, {W_F0, S_BUSY});
      else if (cyc <= 5) check("err_t1_wait", cyc, {obs_word, obs_st}, {W_F1, S_BUSY});
      else               check("err_state", cyc, {obs_word, obs_st}, {18'd0, S_ERR});
      @(posedge clk); #1;
    end
    start = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("err_restart_t0", 10, {obs_word, obs_st}, {W_F0, S_BUSY});
    d1 = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (obs_st[2] && d1 < 0) d1 = k;
    end
    check("err_restart_done", 10, d1, 6);

    // Asynchronous clear during T4 of ld.
    sel = 0; ir_opcode = LD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #1;
    check("clr_pre_t4", 5, {5'd0, obs_word, obs_alu, obs_st}, {5'd0, W_E4, 5'd3, S_BUSY});
    clr = 1'b1; #1;
    check("clr_immediate", 5, {5'd0, obs_word, obs_alu, obs_st}, 32'd0);
    #1 clr = 1'b0;
    for (int k = 6; k <= 7; k++) begin
      @(negedge clk);
      check("clr_idle", k, {5'd0, obs_word, obs_alu, obs_st}, 32'd0);
      @(posedge clk); #1;
    end
    v = '{"post_clr_ldi", 0, LDI, 0, 0, 7, 0, 1'b0};
    run_op(v);

    // start held over two ldi: back-to-back with AUTO_FETCH, via IDLE without.
    for (int s = 1; s >= 0; s--) begin
      sel = s; ir_opcode = LDI; mem_ready = 1'b1; start = 1'b1;
      d1 = -1; d2 = -1; nd = 0;
      for (cyc = 1; cyc <= 17; cyc++) begin
        @(posedge clk); #1;
        if (cyc == ((s == 1) ? 9 : 10)) start = 1'b0;
        @(negedge clk);
        if (obs_st[2]) begin
          nd++;
          if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc;
        end
        if (s == 1 && cyc == 8) check("auto_t0_after_done", cyc, {obs_word, obs_st}, {W_F0, S_BUSY});
        if (s == 0 && cyc == 8) check("manual_idle_after_done", cyc, {obs_word, obs_st}, {18'd0, S_IDLE});
        if (s == 0 && cyc == 9) check("manual_t0", cyc, {obs_word, obs_st}, {W_F0, S_BUSY});
      end
      check(s == 1 ? "auto_done1" : "manual_done1", s, d1, 7);
      check(s == 1 ? "auto_done2" : "manual_done2", s, d2, (s == 1) ? 14 : 15);
      check(s == 1 ? "auto_ndone" : "manual_ndone", s, nd, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
